// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel synchroniser + saturating-count filter with
// registered rise/fall pulses and a combined activity flag.
module multi_debouncer #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned COUNTER_WIDTH = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          RESET_LEVEL   = 1'b0
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                SampleEn,
    input  logic [CHANNELS-1:0] Input,
    output logic [CHANNELS-1:0] Output,
    output logic [CHANNELS-1:0] Rise,
    output logic [CHANNELS-1:0] Fall,
    output logic                Any
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0]   r_sync;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] r_cnt;
    logic [CHANNELS-1:0]                    r_out;
    logic [CHANNELS-1:0]                    r_rise;
    logic [CHANNELS-1:0]                    r_fall;
    logic                                   r_any;

    logic [CHANNELS-1:0]                    w_sync;
    logic [CHANNELS-1:0][COUNTER_WIDTH-1:0] w_cnt_nxt;
    logic [CHANNELS-1:0]                    w_out_nxt;
    logic [CHANNELS-1:0]                    w_rise_nxt;
    logic [CHANNELS-1:0]                    w_fall_nxt;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchroniser shift register; runs every cycle independent of SampleEn.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_sync <= {SYNC_STAGES{ {CHANNELS{RESET_LEVEL}} }};
        end else begin
            r_sync[0] <= Input;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Filter next-state: any agreeing sample clears the count; a differing
    // sample at the saturated count flips the output and emits a pulse.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_out_nxt  = r_out;
        w_rise_nxt = '0;
        w_fall_nxt = '0;
        if (SampleEn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_sync[i] == r_out[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    w_cnt_nxt[i]  = '0;
                    w_out_nxt[i]  = w_sync[i];
                    w_rise_nxt[i] = w_sync[i];
                    w_fall_nxt[i] = ~w_sync[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Filter state and registered pulse outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt  <= '0;
            r_out  <= {CHANNELS{RESET_LEVEL}};
            r_rise <= '0;
            r_fall <= '0;
            r_any  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_out  <= w_out_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_any  <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign Output = r_out;
    assign Rise   = r_rise;
    assign Fall   = r_fall;
    assign Any    = r_any;

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed stimulus with a per-cycle expected-output
// scoreboard plus edge-number checks against the documented latencies.
module tb_multi_debouncer;

    localparam int CH  = 4;
    localparam int W   = 3;
    localparam int SS  = 2;
    localparam int LIM = 1 << W;

    logic          Clk = 1'b0;
    logic          nReset = 1'b1;
    logic          SampleEn = 1'b1;
    logic [CH-1:0] Input = '0;
    logic [CH-1:0] Output, Rise, Fall;
    logic          Any;

    multi_debouncer #(
        .CHANNELS      (CH),
        .COUNTER_WIDTH (W),
        .SYNC_STAGES   (SS),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .SampleEn (SampleEn),
        .Input    (Input),
        .Output   (Output),
        .Rise     (Rise),
        .Fall     (Fall),
        .Any      (Any)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [CH-1:0] o;
        logic [CH-1:0] r;
        logic [CH-1:0] f;
        logic          a;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state
    logic [CH-1:0] m_sync [SS];
    int            m_cnt  [CH];
    logic [CH-1:0] m_out, m_r, m_f;

    // Window observation results
    int w_re [CH];
    int w_fe [CH];
    int w_np [CH];
    int w_any;

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sync[k] = '0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        m_out = '0; m_r = '0; m_f = '0;
    endtask

    task automatic model_edge();
        if (!nReset) begin
            model_reset();
        end else begin
            m_r = '0; m_f = '0;
            if (SampleEn) begin
                for (int c = 0; c < CH; c++) begin
                    if (m_sync[SS-1][c] === m_out[c]) begin
                        m_cnt[c] = 0;
                    end else if (m_cnt[c] == LIM - 1) begin
                        m_cnt[c] = 0;
                        m_out[c] = ~m_out[c];
                        if (m_out[c]) m_r[c] = 1'b1;
                        else          m_f[c] = 1'b1;
                    end else begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end
                end
            end
            for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = Input;
        end
    endtask

    task automatic sb_push();
        exp_t e;
        e.o = m_out; e.r = m_r; e.f = m_f; e.a = |(m_r | m_f);
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        exp_t got;
        e = sb_q.pop_front();
        got.o = Output; got.r = Rise; got.f = Fall; got.a = Any;
        vectors++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: observed out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=%h any=%b",
                   tag, got.o, got.r, got.f, got.a, e.o, e.r, e.f, e.a);
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        sb_push();
        #1;
        sb_check(tag);
    endtask

    // Runs n edges, recording first rise/fall edge per channel (1-based, -1 if
    // none), pulse counts and Any count. Optional gated enable, ch2 toggling
    // every 3 cycles, and dropping Input[0] after edge drop0.
    task automatic window(input string tag, input int n, input bit gated,
                          input bit toggle2, input int drop0);
        for (int c = 0; c < CH; c++) begin
            w_re[c] = -1; w_fe[c] = -1; w_np[c] = 0;
        end
        w_any = 0;
        for (int e = 1; e <= n; e++) begin
            if (gated) SampleEn = ((e % 4) == 3);
            tick(tag);
            for (int c = 0; c < CH; c++) begin
                if (Rise[c] === 1'b1) begin
                    if (w_re[c] < 0) w_re[c] = e;
                    w_np[c]++;
                end
                if (Fall[c] === 1'b1) begin
                    if (w_fe[c] < 0) w_fe[c] = e;
                    w_np[c]++;
                end
            end
            if (Any === 1'b1) w_any++;
            if (toggle2 && (e % 3) == 0) Input[2] = ~Input[2];
            if (e == drop0) Input[0] = 1'b0;
        end
        SampleEn = 1'b1;
    endtask

    task automatic async_reset_check(input string tag);
        nReset = 1'b0;
        model_reset();
        #1;
        sb_push();
        sb_check(tag);
    endtask

    initial begin
        model_reset();

        // Reset with all inputs high, checked before any clock and during reset
        #2;
        Input = 4'hF;
        async_reset_check("reset_async");
        for (int i = 0; i < 3; i++) tick("reset_hold");
        chk("reset_out", int'(Output), 0);
        chk("reset_any", int'(Any), 0);
        Input  = '0;
        nReset = 1'b1;
        for (int i = 0; i < 4; i++) tick("settle");

        // Glitch of 7 cycles is rejected
        Input[0] = 1'b1;
        window("glitch", 27, 1'b0, 1'b0, 7);
        chk("glitch_pulses", w_np[0], 0);
        chk("glitch_out0", int'(Output[0]), 0);

        // Clean rise then fall on channel 0
        Input[0] = 1'b1;
        window("clean_rise", 14, 1'b0, 1'b0, 0);
        chk("rise0_edge", w_re[0], 10);
        chk("rise0_count", w_np[0], 1);
        chk("rise0_any", w_any, 1);
        chk("rise0_others", w_np[1] + w_np[2] + w_np[3], 0);
        chk("rise0_out", int'(Output), 1);
        Input[0] = 1'b0;
        window("clean_fall", 14, 1'b0, 1'b0, 0);
        chk("fall0_edge", w_fe[0], 10);
        chk("fall0_count", w_np[0], 1);

        // Concurrent channels 1 and 3, channel 2 bouncing
        Input[1] = 1'b1;
        Input[3] = 1'b1;
        window("concurrent", 20, 1'b0, 1'b1, 0);
        chk("conc_rise1", w_re[1], 10);
        chk("conc_rise3", w_re[3], 10);
        chk("conc_any", w_any, 1);
        chk("conc_ch2", w_np[2], 0);
        chk("conc_out", int'(Output), 4'hA);
        Input = '0;
        window("conc_release", 14, 1'b0, 1'b0, 0);
        chk("conc_fall1", w_fe[1], 10);
        chk("conc_fall3", w_fe[3], 10);

        // Gated sampling: enables on edges 3,7,11,...
        Input[0] = 1'b1;
        window("gated", 40, 1'b1, 1'b0, 0);
        chk("gated_rise_edge", w_re[0], 31);
        chk("gated_count", w_np[0], 1);
        Input[0] = 1'b0;
        window("gated_release", 14, 1'b0, 1'b0, 0);
        chk("gated_fall_edge", w_fe[0], 10);

        // Reset mid-count discards progress
        Input[0] = 1'b1;
        for (int i = 0; i < 6; i++) tick("midcount");
        async_reset_check("mid_reset_async");
        tick("mid_reset_hold");
        tick("mid_reset_hold");
        chk("mid_reset_out", int'(Output[0]), 0);
        nReset = 1'b1;
        window("after_reset", 14, 1'b0, 1'b0, 0);
        chk("after_reset_rise", w_re[0], 10);
        chk("after_reset_count", w_np[0], 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed no end expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised multi-channel debouncer for mechanical switch and button inputs. It is the successor to the single-channel debouncer. Each channel synchronises an asynchronous input and filters it with its own saturating counter. It exposes the filtered level plus one-cycle rise and fall pulses, so downstream logic needs no separate edge detector. A sample-enable input lets one shared prescaler stretch the debounce window without widening the counters.

## Interface
- CHANNELS, 4, number of independent input channels (≥1)
- COUNTER_WIDTH, 3, per-channel counter width W; filter requires 2^W consecutive differing samples
- SYNC_STAGES, 2, synchroniser flip-flops per channel (≥2)
- RESET_LEVEL, 0, level loaded into synchronisers and filtered outputs on reset (applies to all channels)

- Clk  input  1  system clock, all state on rising edge
- nReset  input  1  asynchronous, active-low reset
- SampleEn  input  1  filter evaluation enable; tie to 1 for per-clock sampling
- Input  input  CHANNELS  raw asynchronous inputs
- Output  output  CHANNELS  debounced stable level per channel
- Rise  output  CHANNELS  one-cycle pulse when Output[i] goes 0→1
- Fall  output  CHANNELS  one-cycle pulse when Output[i] goes 1→0
- Any  output  1  OR of all Rise and Fall bits (registered together with them)

## Operation
- Reset: nReset low immediately forces the following, with no clock needed:
  - every synchroniser stage and Output to RESET_LEVEL
  - all counters to 0
  - Rise, Fall and Any to 0
- Synchroniser: a SYNC_STAGES-deep shift register per channel. It shifts every cycle regardless of SampleEn. Sync[i] is the last stage.
- Filter per channel, evaluated only on cycles with SampleEn=1:
  - Sync[i] == Output[i]: counter ← 0.
  - Sync[i] != Output[i] and counter < 2^W−1: counter ← counter+1.
  - Sync[i] != Output[i] and counter == 2^W−1: Output[i] ← Sync[i], counter ← 0, and Rise[i] or Fall[i] ← 1 according to direction.
- With SampleEn=0, counters and Output hold, and Rise, Fall and Any are 0.
- A single sample agreeing with Output clears the count; there is no partial decay.
- The counter never wraps. Reaching 2^W−1 while differing always causes the flip on that evaluation.
- Channels are fully independent. Simultaneous flips on several channels each pulse their own bit, and Any is 1 for that cycle.
- Rise, Fall and Any are registered. Each pulse is high for exactly one Clk cycle, on the cycle Output changes.
- Output can change at most once per 2^W enabled samples, so pulses on the same channel are never back-to-back.

## Timing
- Let edge 1 be the first rising Clk edge that samples a new Input[i] value. Input is held and SampleEn=1.
  - Sync[i] reflects the new value after edge SYNC_STAGES.
  - Output[i] and its pulse update on edge SYNC_STAGES + 2^W. With defaults this is edge 10.
- Minimum glitch fully rejected: any excursion shorter than 2^W enabled samples, as seen at Sync, i.e. 7 cycles with defaults.
- With SampleEn asserted every N cycles, the filter window is 2^W enabled samples. Synchroniser latency is unchanged.
- Reset mid-count discards all progress. After release, the filter restarts from counter 0 with Output = RESET_LEVEL and no pulse is emitted for the reset.
- nReset release is assumed synchronous to Clk externally. The block adds no reset synchroniser.

## Test plan
- Reset: defaults, RESET_LEVEL=0, nReset low for 3 cycles with Input=4'hF → Output=0, Rise=Fall=0, Any=0 throughout reset.
- Glitch rejection: after reset, Input[0]=1 for 7 cycles then 0, SampleEn=1 → Output[0] stays 0, and no Rise or Fall pulse occurs over the next 20 cycles.
- Clean transition: Input[0] held 1 → Output[0] becomes 1 on edge 10. Rise[0] and Any are 1 for exactly that one cycle. Other channels are unchanged. Releasing Input[0] to 0 gives Fall[0] 10 edges later.
- Concurrent channels: Input[1] and Input[3] rise on the same edge, Input[2] toggles every 3 cycles → Rise[1] and Rise[3] pulse on the same cycle, with Any=1 once. Output[2] never changes.
- SampleEn gating: SampleEn high 1 cycle in 4, Input[0] held 1 → Output[0] rises after the 8th enabled sample following sync (edge 2+29=31 with aligned enables). Rise[0] pulses on that edge only.
- Reset mid-operation: Input[0]=1, nReset asserted after 6 cycles then released → counter cleared and Output[0]=0. A full 10 edges after release are again required before Rise[0].
